// File: rtl/mips_execute_stage_if.sv
// ID->EX operand/control bundle and EX/MEM latch outputs for mips_execute_stage.
// master = ID-side driver, slave = execute stage.
interface mips_execute_stage_if #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9,
    parameter int NB_CTRL_EX           = 11
);
    logic [LEN-1:0]                  i_adder_id;
    logic [LEN-1:0]                  i_dato1;
    logic [LEN-1:0]                  i_dato2;
    logic [LEN-1:0]                  i_sign_extend;
    logic [NB_CTRL_WB-1:0]           i_ctrl_wb;
    logic [NB_CTRL_MEM-1:0]          i_ctrl_mem;
    logic [NB_CTRL_EX-1:0]           i_ctrl_ex;
    logic [NB_ADDRESS_REGISTROS-1:0] i_rd;
    logic [NB_ADDRESS_REGISTROS-1:0] i_rt;
    logic [NB_ADDRESS_REGISTROS-1:0] i_shamt;
    logic [1:0]                      i_ctrl_muxA_corto;
    logic [1:0]                      i_ctrl_muxB_corto;
    logic [LEN-1:0]                  i_rd_mem_corto;
    logic [LEN-1:0]                  i_rd_wb_corto;
    logic                            i_flush;
    logic                            o_alu_zero;
    logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg;
    logic [NB_CTRL_WB-1:0]           o_ctrl_wb;
    logic [NB_CTRL_MEM-1:0]          o_ctrl_mem;
    logic [LEN-1:0]                  o_pc_branch;
    logic [LEN-1:0]                  o_alu_result;
    logic [LEN-1:0]                  o_dato2;

    modport master (
        output i_adder_id, i_dato1, i_dato2, i_sign_extend, i_ctrl_wb, i_ctrl_mem,
               i_ctrl_ex, i_rd, i_rt, i_shamt, i_ctrl_muxA_corto, i_ctrl_muxB_corto,
               i_rd_mem_corto, i_rd_wb_corto, i_flush,
        input  o_alu_zero, o_write_reg, o_ctrl_wb, o_ctrl_mem, o_pc_branch,
               o_alu_result, o_dato2
    );

    modport slave (
        input  i_adder_id, i_dato1, i_dato2, i_sign_extend, i_ctrl_wb, i_ctrl_mem,
               i_ctrl_ex, i_rd, i_rt, i_shamt, i_ctrl_muxA_corto, i_ctrl_muxB_corto,
               i_rd_mem_corto, i_rd_wb_corto, i_flush,
        output o_alu_zero, o_write_reg, o_ctrl_wb, o_ctrl_mem, o_pc_branch,
               o_alu_result, o_dato2
    );
endinterface

// File: rtl/mips_execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, branch target, dest reg into the EX/MEM latch.
// Latency 1 cycle; no backpressure (pipeline advances every cycle, flush inserts a bubble).
// Operand forwarding muxes are enabled by defining EX_FORWARDING_EN.
module mips_execute_stage #(
    parameter int LEN                  = 32,
    parameter int NB_ALU_CONTROL       = 4,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9,
    parameter int NB_CTRL_EX           = 11
) (
    input logic              i_clk,
    input logic              i_rst,
    mips_execute_stage_if.slave ex
);
    logic [LEN-1:0]                  f_a;
    logic [LEN-1:0]                  f_b;
    logic [LEN-1:0]                  op_a;
    logic [LEN-1:0]                  op_b;
    logic [LEN-1:0]                  alu_out;
    logic [LEN-1:0]                  result;
    logic [LEN-1:0]                  pc_branch;
    logic [NB_ADDRESS_REGISTROS-1:0] write_reg;
    logic [NB_ALU_CONTROL-1:0]       alu_code;
    logic [4:0]                      sh_amt;
    logic                            jal, jalr, reg_dst, alu_src1, alu_src2;

    assign jal      = ex.i_ctrl_ex[10];
    assign jalr     = ex.i_ctrl_ex[7];
    assign reg_dst  = ex.i_ctrl_ex[6];
    assign alu_src1 = ex.i_ctrl_ex[5];
    assign alu_src2 = ex.i_ctrl_ex[4];
    assign alu_code = ex.i_ctrl_ex[NB_ALU_CONTROL-1:0];

    // Jump and JR are resolved in ID; their bits only ride along in the bundle.
    logic unused_ctrl;
    assign unused_ctrl = ^ex.i_ctrl_ex[9:8];

`ifdef EX_FORWARDING_EN
    always_comb begin
        case (ex.i_ctrl_muxA_corto)
            2'b01:   f_a = ex.i_rd_mem_corto;
            2'b10:   f_a = ex.i_rd_wb_corto;
            default: f_a = ex.i_dato1;
        endcase
        case (ex.i_ctrl_muxB_corto)
            2'b01:   f_b = ex.i_rd_mem_corto;
            2'b10:   f_b = ex.i_rd_wb_corto;
            default: f_b = ex.i_dato2;
        endcase
    end
`else
    assign f_a = ex.i_dato1;
    assign f_b = ex.i_dato2;

    logic unused_fwd;
    assign unused_fwd = ^{ex.i_ctrl_muxA_corto, ex.i_ctrl_muxB_corto,
                          ex.i_rd_mem_corto, ex.i_rd_wb_corto};
`endif

    assign op_a   = alu_src1 ? {{(LEN-NB_ADDRESS_REGISTROS){1'b0}}, ex.i_shamt} : f_a;
    assign op_b   = alu_src2 ? ex.i_sign_extend : f_b;
    assign sh_amt = op_a[4:0];

    always_comb begin
        alu_out = '0;
        case (alu_code)
            4'b0000: alu_out = op_b << sh_amt;
            4'b0001: alu_out = op_b >> sh_amt;
            4'b0010: alu_out = $signed(op_b) >>> sh_amt;
            4'b0011: alu_out = op_b + op_a;
            4'b0100: alu_out = op_a - op_b;
            4'b0101: alu_out = op_a & op_b;
            4'b0110: alu_out = op_a | op_b;
            4'b0111: alu_out = op_a ^ op_b;
            4'b1000: alu_out = ~(op_a | op_b);
            4'b1001: alu_out = {{(LEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1010: alu_out = {{(LEN-1){1'b0}}, (op_a < op_b)};
            4'b1011: alu_out = op_b << 16;
            default: alu_out = '0;
        endcase
    end

    // Link instructions write the return address (PC+4) instead of the ALU value.
    assign result    = (jal || jalr) ? ex.i_adder_id : alu_out;
    assign write_reg = jal ? NB_ADDRESS_REGISTROS'(31) : (reg_dst ? ex.i_rd : ex.i_rt);
    assign pc_branch = ex.i_adder_id + (ex.i_sign_extend << 2);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ex.o_alu_zero   <= 1'b0;
            ex.o_write_reg  <= '0;
            ex.o_ctrl_wb    <= '0;
            ex.o_ctrl_mem   <= '0;
            ex.o_pc_branch  <= '0;
            ex.o_alu_result <= '0;
            ex.o_dato2      <= '0;
        end else begin
            ex.o_alu_zero   <= (result == '0);
            ex.o_write_reg  <= write_reg;
            ex.o_ctrl_wb    <= ex.i_flush ? '0 : ex.i_ctrl_wb;
            ex.o_ctrl_mem   <= ex.i_flush ? '0 : ex.i_ctrl_mem;
            ex.o_pc_branch  <= pc_branch;
            ex.o_alu_result <= result;
            ex.o_dato2      <= f_b;
        end
    end
endmodule

// File: tb/tb_mips_execute_stage.sv
// Directed bench for mips_execute_stage: inputs change 1ns after a rising edge,
// outputs are checked 1ns after the edge that latches them.
module tb_mips_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mips_execute_stage_if bus ();

    mips_execute_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .ex    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        bus.i_adder_id        = 32'h40;
        bus.i_dato1           = 32'd7;
        bus.i_dato2           = 32'd5;
        bus.i_sign_extend     = 32'd0;
        bus.i_ctrl_wb         = 2'b11;
        bus.i_ctrl_mem        = 9'h1FF;
        bus.i_ctrl_ex         = 11'h003;
        bus.i_rd              = 5'd8;
        bus.i_rt              = 5'd3;
        bus.i_shamt           = 5'd0;
        bus.i_ctrl_muxA_corto = 2'b00;
        bus.i_ctrl_muxB_corto = 2'b00;
        bus.i_rd_mem_corto    = 32'h0;
        bus.i_rd_wb_corto     = 32'h0;
        bus.i_flush           = 1'b0;
    endtask

    initial begin
        defaults();

        // Reset held for two edges with nonzero inputs.
        rst = 1'b0;
        tick();
        tick();
        check("rst_result", bus.o_alu_result, 32'h0);
        check("rst_zero",   {31'b0, bus.o_alu_zero}, 32'h0);
        check("rst_wreg",   {27'b0, bus.o_write_reg}, 32'h0);
        check("rst_wb",     {30'b0, bus.o_ctrl_wb}, 32'h0);
        check("rst_mem",    {23'b0, bus.o_ctrl_mem}, 32'h0);
        check("rst_pcbr",   bus.o_pc_branch, 32'h0);
        check("rst_dato2",  bus.o_dato2, 32'h0);

        // Release: ADD 7+5 appears on the next edge.
        rst = 1'b1;
        tick();
        check("add_result", bus.o_alu_result, 32'd12);
        check("add_zero",   {31'b0, bus.o_alu_zero}, 32'h0);
        check("add_dato2",  bus.o_dato2, 32'd5);
        check("add_wreg",   {27'b0, bus.o_write_reg}, 32'd3);
        check("add_wb",     {30'b0, bus.o_ctrl_wb}, 32'h3);
        check("add_mem",    {23'b0, bus.o_ctrl_mem}, 32'h1FF);
        check("add_pcbr",   bus.o_pc_branch, 32'h40);

        // SUB 9-9 -> zero flag.
        bus.i_ctrl_ex = 11'h004;
        bus.i_dato1   = 32'd9;
        bus.i_dato2   = 32'd9;
        tick();
        check("sub_result", bus.o_alu_result, 32'h0);
        check("sub_zero",   {31'b0, bus.o_alu_zero}, 32'h1);

        // Forwarding A from MEM, B from WB.
        bus.i_ctrl_ex         = 11'h003;
        bus.i_dato1           = 32'd7;
        bus.i_dato2           = 32'd5;
        bus.i_ctrl_muxA_corto = 2'b01;
        bus.i_ctrl_muxB_corto = 2'b10;
        bus.i_rd_mem_corto    = 32'h100;
        bus.i_rd_wb_corto     = 32'h20;
        tick();
`ifdef EX_FORWARDING_EN
        check("fwd_result", bus.o_alu_result, 32'h120);
        check("fwd_dato2",  bus.o_dato2, 32'h20);
`else
        check("fwd_result", bus.o_alu_result, 32'd12);
        check("fwd_dato2",  bus.o_dato2, 32'd5);
`endif
        bus.i_ctrl_muxA_corto = 2'b00;
        bus.i_ctrl_muxB_corto = 2'b00;

        // Immediate -1 + 1 wraps to 0; branch target with negative offset.
        bus.i_ctrl_ex     = 11'h013;
        bus.i_sign_extend = 32'hFFFF_FFFF;
        bus.i_dato1       = 32'd1;
        tick();
        check("imm_result", bus.o_alu_result, 32'h0);
        check("imm_zero",   {31'b0, bus.o_alu_zero}, 32'h1);
        check("imm_pcbr",   bus.o_pc_branch, 32'h3C);

        // SRA by shamt=4.
        bus.i_ctrl_ex     = 11'h022;
        bus.i_shamt       = 5'd4;
        bus.i_dato2       = 32'h8000_0000;
        bus.i_sign_extend = 32'd0;
        tick();
        check("sra_result", bus.o_alu_result, 32'hF800_0000);
        check("sra_dato2",  bus.o_dato2, 32'h8000_0000);

        // LUI 0x1234.
        bus.i_ctrl_ex     = 11'h01B;
        bus.i_sign_extend = 32'h1234;
        tick();
        check("lui_result", bus.o_alu_result, 32'h1234_0000);
        check("lui_pcbr",   bus.o_pc_branch, 32'h4910);

        // Branch target 0x40 + (3<<2).
        bus.i_ctrl_ex     = 11'h003;
        bus.i_sign_extend = 32'd3;
        bus.i_dato1       = 32'd7;
        bus.i_dato2       = 32'd5;
        tick();
        check("br_pcbr",   bus.o_pc_branch, 32'h4C);
        check("br_result", bus.o_alu_result, 32'd12);

        // JAL: link address into r31.
        bus.i_ctrl_ex = 11'h403;
        tick();
        check("jal_wreg",   {27'b0, bus.o_write_reg}, 32'd31);
        check("jal_result", bus.o_alu_result, 32'h40);
        check("jal_zero",   {31'b0, bus.o_alu_zero}, 32'h0);

        // JALR with RegDst: link address into rd.
        bus.i_ctrl_ex = 11'h0C3;
        tick();
        check("jalr_wreg",   {27'b0, bus.o_write_reg}, 32'd8);
        check("jalr_result", bus.o_alu_result, 32'h40);

        // RegDst ADD.
        bus.i_ctrl_ex = 11'h043;
        tick();
        check("rd_wreg",   {27'b0, bus.o_write_reg}, 32'd8);
        check("rd_result", bus.o_alu_result, 32'd12);

        // Signed vs unsigned compare of -1 against 1.
        bus.i_ctrl_ex = 11'h009;
        bus.i_dato1   = 32'hFFFF_FFFF;
        bus.i_dato2   = 32'd1;
        tick();
        check("slt_result", bus.o_alu_result, 32'd1);
        bus.i_ctrl_ex = 11'h00A;
        tick();
        check("sltu_result", bus.o_alu_result, 32'd0);
        check("sltu_zero",   {31'b0, bus.o_alu_zero}, 32'h1);

        // Flush bubbles the control; data still updates.
        bus.i_ctrl_ex  = 11'h003;
        bus.i_dato1    = 32'd7;
        bus.i_dato2    = 32'd5;
        bus.i_ctrl_wb  = 2'b10;
        bus.i_ctrl_mem = 9'h002;
        bus.i_flush    = 1'b1;
        tick();
        check("flush_wb",     {30'b0, bus.o_ctrl_wb}, 32'h0);
        check("flush_mem",    {23'b0, bus.o_ctrl_mem}, 32'h0);
        check("flush_result", bus.o_alu_result, 32'd12);
        bus.i_flush = 1'b0;
        tick();
        check("unflush_wb",  {30'b0, bus.o_ctrl_wb}, 32'h2);
        check("unflush_mem", {23'b0, bus.o_ctrl_mem}, 32'h002);

        // Reset wins over flush and clears data as well.
        rst         = 1'b0;
        bus.i_flush = 1'b1;
        tick();
        check("rstflush_result", bus.o_alu_result, 32'h0);
        check("rstflush_pcbr",   bus.o_pc_branch, 32'h0);
        check("rstflush_wreg",   {27'b0, bus.o_write_reg}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
